out_sched: RTL
==============

# out_sched

Output-port scheduler for the Q16 core. Sits between the execute stage's OUT strobe and the two 16-bit output channels (A, B). It captures the selected register value together with a channel mask into a small in-order queue, then drives each channel with a valid/ready handshake. The core is stalled while the queue is full, so slow peripherals never lose writes.

## Interface
- DEPTH, 4: queue entries; power of two, 2..16
- TIMEOUT, 255: handshake watchdog limit in cycles (used only with OUT_SCHED_TIMEOUT_EN)
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- s  in  1  execute strobe
- inter  in  1  interrupt in progress; suppresses capture
- outA, outB  in  1 each  target channel A / B for this OUT
- reg1  in  2  source register index
- sreg1..sreg4  in  16 each  register file values
- stall  out  1  queue full; core must hold the OUT
- busy  out  1  queue non-empty or transfer in progress
- a_data, b_data  out  16 each  channel data
- a_valid, b_valid  out  1 each  channel data valid
- a_ready, b_ready  in  1 each  peripheral accepts
- err  out  1  sticky timeout flag (macro builds only)

## Operation
- Capture: when s & (outA|outB) & ~inter & ~stall, push entry {mask={outB,outA}, data=sreg[reg1]}. reg1 0..3 selects sreg1..sreg4.
- Requests with mask 00, with inter=1, or with stall=1 are ignored, with no side effects.
- Entries are delivered strictly in order. There is one head entry at a time.
- FSM:
  - IDLE -> SEND when the queue is non-empty.
  - SEND: for each channel in the head mask whose done bit is clear, drive valid=1 with data=head data.
  - A channel's done bit sets on the cycle valid&ready is high.
  - When all masked channels are done, pop the head. Go to SEND if more entries remain, otherwise IDLE.
- Mask 11: both channels receive the same data. The head retires only after both accept, in either order or in the same cycle.
- Data on a channel is stable while its valid is high. Valid never drops without ready.
- Full queue: stall = (count==DEPTH), combinational from registered count. A push is refused while full, even if a pop occurs in the same cycle. Push and pop in the same cycle when not full leaves count unchanged.
- Pointers wrap modulo DEPTH.
- busy = (count!=0).

## Timing
- Reset: stall=0, busy=0, a_valid=b_valid=0, a_data=b_data=0, err=0, FSM=IDLE, count=0, done bits cleared.
- Reset asserted mid-transfer aborts the transfer immediately. All queued entries are discarded.
- a/b_valid and a/b_data are registered.
- Capture in cycle N: queue write at edge N. With the FSM IDLE, valid is high in cycle N+1.
- Back-to-back: on a head pop at edge M, the next entry's valid/data appear in cycle M+1. Throughput is 1 entry/cycle with ready tied high.
- A channel not in the head mask keeps valid=0. Its data holds its last value.

## Configuration
- OUT_SCHED_TIMEOUT_EN defined:
  - A per-head counter increments each SEND cycle in which some masked channel is not yet done. It clears on pop.
  - When the counter reaches TIMEOUT, the head is force-popped, valids drop next cycle, and err sets. err is sticky until reset.
- OUT_SCHED_TIMEOUT_EN undefined:
  - No counter is built, and SEND waits indefinitely.
  - err is tied to 0.

## Structure
- Package out_sched_pkg:
  - state enum {IDLE, SEND}
  - entry struct {logic[1:0] mask; logic[15:0] data}
  - mask constants CH_A=2'b01, CH_B=2'b10
  - data width constant 16
- Sub-module out_sched_fifo: DEPTH-entry synchronous queue with push, pop, full, empty and count. It uses the same clk/rst and resets to empty.
- The top level holds the FSM, per-channel done bits and the optional watchdog.

## Test plan
- Reset, then OUT reg1=2, outA, sreg3=0x1234, a_ready=1 -> a_valid=1 with a_data=0x1234 in cycle N+1 only. b_valid stays 0 and busy returns to 0.
- outA=outB=1, sreg1=0xBEEF, a_ready=1, b_ready held 0 for 5 cycles -> a_valid drops after acceptance, b_valid stays 1 until b_ready, then the entry pops.
- With a_ready=0, issue 5 OUTs to A at DEPTH=4 -> stall=1 after the 4th and the 5th is refused. Release ready -> data out in order 1..4.
- OUT with inter=1, then with s=0 -> no capture, busy stays 0.
- Assert rst low while a_valid=1 with 3 entries queued -> all outputs 0 asynchronously. After release, no stale data appears.
- With OUT_SCHED_TIMEOUT_EN, TIMEOUT=8, a_ready=0 -> head dropped after 8 SEND cycles, err=1 and sticky, next entry presented.

Source files
------------

// File: rtl/out_sched_pkg.sv
// Shared types and constants for the Q16 output-port scheduler.
package out_sched_pkg;

    localparam int DW = 16;

    localparam logic [1:0] CH_A = 2'b01;
    localparam logic [1:0] CH_B = 2'b10;

    typedef enum logic {IDLE, SEND} state_e;

    typedef struct packed {
        logic [1:0]    mask;
        logic [DW-1:0] data;
    } entry_t;

endpackage

// File: rtl/out_sched_fifo.sv
// In-order entry queue for out_sched; exposes the head and the entry behind it
// so the scheduler can present the next entry on the same edge it pops.
module out_sched_fifo
    import out_sched_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  entry_t                   push_ent_i,
    input  logic                     pop_i,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output entry_t                   head_o,
    output entry_t                   head_nxt_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    entry_t          mem_q [DEPTH];
    logic [PW-1:0]   wr_q, rd_q;
    logic [CW-1:0]   cnt_q;
    logic            do_push, do_pop;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    assign head_o     = mem_q[rd_q];
    assign head_nxt_o = mem_q[rd_q + PW'(1)];

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= push_ent_i;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + PW'(1);
            if (do_pop)  rd_q <= rd_q + PW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/out_sched.sv
// Q16 output-port scheduler: queues OUT writes and drives channels A/B with valid/ready.
// Optional handshake watchdog enabled by defining OUT_SCHED_TIMEOUT_EN.
module out_sched
    import out_sched_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s,
    input  logic          inter,
    input  logic          outA,
    input  logic          outB,
    input  logic [1:0]    reg1,
    input  logic [DW-1:0] sreg1,
    input  logic [DW-1:0] sreg2,
    input  logic [DW-1:0] sreg3,
    input  logic [DW-1:0] sreg4,
    output logic          stall,
    output logic          busy,
    output logic [DW-1:0] a_data,
    output logic [DW-1:0] b_data,
    output logic          a_valid,
    output logic          b_valid,
    input  logic          a_ready,
    input  logic          b_ready,
    output logic          err
);

    localparam int CW = $clog2(DEPTH) + 1;

    state_e          state_q, state_d;
    logic [1:0]      done_q, done_d;
    logic            av_q, av_d, bv_q, bv_d;
    logic [DW-1:0]   ad_q, ad_d, bd_q, bd_d;

    logic [1:0]      req_mask, hs;
    logic [DW-1:0]   sel_data;
    logic            push, pop, all_done, force_pop;
    logic            full, empty, load, nxt_avail;
    logic [CW-1:0]   count;
    entry_t          push_ent, head, head_nxt, nxt_ent;

    assign req_mask = {outB, outA};

    always_comb begin
        sel_data = sreg1;
        case (reg1)
            2'd0: sel_data = sreg1;
            2'd1: sel_data = sreg2;
            2'd2: sel_data = sreg3;
            2'd3: sel_data = sreg4;
            default: sel_data = sreg1;
        endcase
    end

    assign push     = s & (|req_mask) & ~inter & ~stall;
    assign push_ent = '{mask: req_mask, data: sel_data};

    out_sched_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (push),
        .push_ent_i (push_ent),
        .pop_i      (pop),
        .full_o     (full),
        .empty_o    (empty),
        .count_o    (count),
        .head_o     (head),
        .head_nxt_o (head_nxt)
    );

    assign stall = full;
    assign busy  = (count != '0);

    assign hs       = {bv_q & b_ready, av_q & a_ready};
    assign all_done = (((done_q | hs) & head.mask) == head.mask);
    assign pop      = (state_q == SEND) & (all_done | force_pop);

    // Whenever a new head is loaded (from IDLE or on a pop) it may come straight
    // from this cycle's push, so an OUT to an empty queue shows valid next cycle.
    always_comb begin
        state_d   = state_q;
        done_d    = done_q | hs;
        av_d      = av_q & ~a_ready;
        bv_d      = bv_q & ~b_ready;
        ad_d      = ad_q;
        bd_d      = bd_q;
        load      = 1'b0;
        nxt_avail = 1'b0;
        nxt_ent   = push_ent;
        case (state_q)
            IDLE: begin
                load      = 1'b1;
                nxt_avail = ~empty | push;
                nxt_ent   = empty ? push_ent : head;
            end
            SEND: begin
                if (pop) begin
                    load      = 1'b1;
                    nxt_avail = (count > CW'(1)) | push;
                    nxt_ent   = (count > CW'(1)) ? head_nxt : push_ent;
                end
            end
            default: state_d = IDLE;
        endcase
        if (load) begin
            state_d = nxt_avail ? SEND : IDLE;
            done_d  = '0;
            av_d    = nxt_avail & nxt_ent.mask[0];
            bv_d    = nxt_avail & nxt_ent.mask[1];
            if (av_d) ad_d = nxt_ent.data;
            if (bv_d) bd_d = nxt_ent.data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            done_q  <= '0;
            av_q    <= 1'b0;
            bv_q    <= 1'b0;
            ad_q    <= '0;
            bd_q    <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            av_q    <= av_d;
            bv_q    <= bv_d;
            ad_q    <= ad_d;
            bd_q    <= bd_d;
        end
    end

    assign a_valid = av_q;
    assign b_valid = bv_q;
    assign a_data  = ad_q;
    assign b_data  = bd_q;

`ifdef OUT_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] wd_q;
    logic          err_q;

    // The head is dropped at the end of its TIMEOUT-th waiting SEND cycle.
    assign force_pop = (state_q == SEND) & ~all_done & (wd_q == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            if (load)
                wd_q <= '0;
            else if ((state_q == SEND) && !all_done)
                wd_q <= wd_q + TW'(1);
            if (force_pop) err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign force_pop = 1'b0;
    assign err       = 1'b0;
`endif

endmodule
